// File: rtl/dll_index_tracker_pkg.sv
// dll_index_tracker_pkg
// Shared constants for the DLL truncation index tracker and the truncation
// stage it feeds: accumulator/window/index widths, the allowed index range,
// the tracker state encoding and the peak-bit to window-index conversion.
package dll_index_tracker_pkg;

  localparam int ACC_WIDTH        = 36;
  localparam int OUT_WIDTH        = 11;
  localparam int IDX_WIDTH        = 6;
  localparam int MIN_INDEX        = OUT_WIDTH - 1;
  localparam int HOLD_PERIODS_DEF = 4;
  localparam int INIT_INDEX_DEF   = 35;

  localparam logic [IDX_WIDTH-1:0] MIN_IDX = IDX_WIDTH'(MIN_INDEX);
  localparam logic [IDX_WIDTH-1:0] MAX_IDX = IDX_WIDTH'(ACC_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_UPDATE = 2'd2
  } dll_state_e;

  // Window MSB sits one bit above the peak's leading one so the sign bit of
  // the largest sample still lands inside the truncated word.
  function automatic logic [IDX_WIDTH-1:0] clampTarget(input logic [IDX_WIDTH-1:0] p);
    logic [IDX_WIDTH:0] t;
    t = {1'b0, p} + 1'b1;
    if (t < {1'b0, MIN_IDX}) begin
      return MIN_IDX;
    end else if (t > {1'b0, MAX_IDX}) begin
      return MAX_IDX;
    end
    return t[IDX_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/dll_index_tracker_abs_max.sv
// dll_abs_max
// Magnitude of each signed accumulator sample and the running peak of those
// magnitudes over one integration period.
//   clk, reset_n       : clock, asynchronous active-low reset
//   acc_valid_i, acc_i : sample strobe and signed sample
//   dump_i             : end-of-period strobe; peak restarts from zero
//   closing_peak_o     : peak of the period including any sample in this cycle
module dll_abs_max
  import dll_index_tracker_pkg::*;
#(
  parameter int W = ACC_WIDTH
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         acc_valid_i,
  input  logic [W-1:0] acc_i,
  input  logic         dump_i,
  output logic [W-1:0] closing_peak_o
);

  logic [W-1:0] mag;
  logic [W-1:0] closing;
  logic [W-1:0] peak_q;
  logic [W-1:0] peak_d;

  // The most negative input maps to 2^(W-1), which still fits unsigned.
  always_comb begin
    mag = acc_i[W-1] ? (~acc_i + 1'b1) : acc_i;
  end

  // A sample coincident with dump belongs to the closing period, so it is
  // folded into the closing value but never into the new period.
  always_comb begin
    closing = peak_q;
    if (acc_valid_i && (mag > peak_q)) begin
      closing = mag;
    end
    peak_d = dump_i ? '0 : closing;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign closing_peak_o = closing;

endmodule

// File: rtl/dll_index_tracker.sv
// dll_index_tracker
// Tracks the truncation index for the 36-to-11-bit DLL correlator truncation
// stage. At each dump the period peak magnitude is scanned MSB-first for its
// leading one; the derived window index rises at once and decays by one step
// only after HOLD_PERIODS consecutive lower-target periods.
//   clk, reset_n    : clock, asynchronous active-low reset
//   acc_valid, acc_in : signed accumulator samples
//   dump            : end-of-integration-period strobe
//   index           : current truncation index (10..35)
//   index_valid     : one-cycle pulse when index reflects a new decision
//   busy            : scan/update in progress
//   overrun         : one-cycle pulse, dump arrived while scanning
module dll_index_tracker
  import dll_index_tracker_pkg::*;
#(
  parameter int HOLD_PERIODS = HOLD_PERIODS_DEF,
  parameter int INIT_INDEX   = INIT_INDEX_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 acc_valid,
  input  logic [ACC_WIDTH-1:0] acc_in,
  input  logic                 dump,
  output logic [IDX_WIDTH-1:0] index,
  output logic                 index_valid,
  output logic                 busy,
  output logic                 overrun
);

  localparam int HOLD_WIDTH = $clog2(HOLD_PERIODS + 1);
  localparam logic [HOLD_WIDTH-1:0] HOLD_LIMIT = HOLD_WIDTH'(HOLD_PERIODS);

  logic [ACC_WIDTH-1:0]  closing_peak;
  dll_state_e            state_q;
  logic [IDX_WIDTH-1:0]  ptr_q;
  logic [ACC_WIDTH-1:0]  snap_q;
  logic [IDX_WIDTH-1:0]  index_q;
  logic [HOLD_WIDTH-1:0] hold_q;
  logic                  valid_q;
  logic                  busy_q;
  logic                  overrun_q;
  logic [IDX_WIDTH-1:0]  target_d;
  logic [HOLD_WIDTH-1:0] hold_d;

  dll_abs_max #(
    .W (ACC_WIDTH)
  ) u_abs_max (
    .clk            (clk),
    .reset_n        (reset_n),
    .acc_valid_i    (acc_valid),
    .acc_i          (acc_in),
    .dump_i         (dump),
    .closing_peak_o (closing_peak)
  );

  // ptr_q stops on the leading-one position, so it doubles as p in UPDATE.
  always_comb begin
    target_d = clampTarget(ptr_q);
    hold_d   = hold_q + 1'b1;
  end

  // busy stays high through the index_valid cycle (state already IDLE) and
  // drops on the following edge unless a new dump starts another scan.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= MAX_IDX;
      snap_q    <= '0;
      index_q   <= IDX_WIDTH'(INIT_INDEX);
      hold_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      overrun_q <= dump && (state_q != ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          if (dump) begin
            snap_q  <= closing_peak;
            ptr_q   <= MAX_IDX;
            busy_q  <= 1'b1;
            state_q <= ST_SEARCH;
          end else begin
            busy_q <= 1'b0;
          end
        end
        ST_SEARCH: begin
          busy_q <= 1'b1;
          if (snap_q[ptr_q] || (ptr_q == '0)) begin
            state_q <= ST_UPDATE;
          end else begin
            ptr_q <= ptr_q - 1'b1;
          end
        end
        ST_UPDATE: begin
          busy_q  <= 1'b1;
          valid_q <= 1'b1;
          state_q <= ST_IDLE;
          if (target_d > index_q) begin
            index_q <= target_d;
            hold_q  <= '0;
          end else if (target_d == index_q) begin
            hold_q <= '0;
          end else if (hold_d == HOLD_LIMIT) begin
            index_q <= index_q - 1'b1;
            hold_q  <= '0;
          end else begin
            hold_q <= hold_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign index       = index_q;
  assign index_valid = valid_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_dll_index_tracker.sv
// tb_dll_index_tracker
// Scoreboard bench: stimulus updates a period-level reference model and queues
// the expected index_valid/overrun events; a negedge monitor compares them
// against the DUT together with busy and index stability.
module tb_dll_index_tracker;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        acc_valid;
  logic [35:0] acc_in;
  logic        dump;
  logic [5:0]  index;
  logic        index_valid;
  logic        busy;
  logic        overrun;

  dll_index_tracker dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .acc_valid   (acc_valid),
    .acc_in      (acc_in),
    .dump        (dump),
    .index       (index),
    .index_valid (index_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int cycleCount = 0;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  typedef struct {
    int cycle;
    int idx;
  } exp_t;

  exp_t expQ[$];
  int   ovQ[$];
  int   assertCount = 0;
  int   failCount = 0;

  longint mPeak;
  int     mIndex;
  int     mHold;
  int     bStart0, bEnd0, bStart1, bEnd1;
  int     lastIdx;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual=%0d required=%0d (cycle %0d)", name, actual, expected, cycleCount);
    end
  endtask

  task automatic modelReset();
    mPeak   = 0;
    mIndex  = 35;
    mHold   = 0;
    bStart0 = 0;
    bEnd0   = -1;
    bStart1 = 0;
    bEnd1   = -1;
    lastIdx = 35;
    expQ.delete();
    ovQ.delete();
  endtask

  // Period decision taken from the dump sampled at edge edgeN.
  task automatic modelDump(input int edgeN);
    int   p;
    int   target;
    exp_t e;
    if (edgeN <= bEnd0) begin
      ovQ.push_back(edgeN);
    end else begin
      p = 0;
      while ((mPeak >> (p + 1)) != 0) p++;
      target = p + 1;
      if (target < 10) target = 10;
      if (target > 35) target = 35;
      if (target > mIndex) begin
        mIndex = target;
        mHold  = 0;
      end else if (target == mIndex) begin
        mHold = 0;
      end else begin
        mHold++;
        if (mHold == 4) begin
          mIndex--;
          mHold = 0;
        end
      end
      e.cycle = edgeN + 37 - p;
      e.idx   = mIndex;
      expQ.push_back(e);
      bStart1 = bStart0;
      bEnd1   = bEnd0;
      bStart0 = edgeN;
      bEnd0   = e.cycle;
    end
    mPeak = 0;
  endtask

  task automatic applyStimulus(input logic v, input logic [35:0] x, input logic d);
    logic signed [35:0] s;
    longint             mag;
    @(posedge clk);
    #1;
    acc_valid = v;
    acc_in    = x;
    dump      = d;
    if (v) begin
      s   = x;
      mag = s;
      if (mag < 0) mag = -mag;
      if (mag > mPeak) mPeak = mag;
    end
    if (d) modelDump(cycleCount + 1);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 36'd0, 1'b0);
  endtask

  task automatic fixedPeriod(input logic [35:0] big, input int len);
    applyStimulus(1'b1, big, 1'b0);
    for (int i = 0; i < len - 2; i++) applyStimulus(1'($urandom_range(0, 1)), 36'h F_FFFF_FFF9, 1'b0);
    applyStimulus(1'b0, 36'd0, 1'b1);
  endtask

  function automatic logic [35:0] randSample(input int minShift);
    logic [63:0] r;
    logic [35:0] m;
    r = {$urandom, $urandom};
    m = r[35:0] >> $urandom_range(minShift, 35);
    if ($urandom_range(0, 19) == 0) m = 36'h8_0000_0000;
    else if ($urandom_range(0, 1) == 1) m = -m;
    return m;
  endfunction

  task automatic randomPeriod(input int len);
    int sh;
    sh = $urandom_range(0, 34);
    for (int i = 0; i < len - 1; i++) applyStimulus(1'($urandom_range(0, 1)), randSample(sh), 1'b0);
    applyStimulus(1'($urandom_range(0, 1)), randSample(sh), 1'b1);
  endtask

  task automatic doReset(input int n);
    @(posedge clk);
    #1;
    reset_n   = 1'b0;
    acc_valid = 1'b0;
    dump      = 1'b0;
    modelReset();
    #1;
    checkOutput("reset_index", index, 35);
    checkOutput("reset_index_valid", index_valid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_overrun", overrun, 0);
    repeat (n) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  exp_t monE;
  int   monC;
  logic expBusy;

  always @(negedge clk) begin
    if (index_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_index_valid", index_valid, 0);
      end else begin
        monE = expQ.pop_front();
        checkOutput("valid_latency", cycleCount, monE.cycle);
        checkOutput("valid_index", index, monE.idx);
        lastIdx = monE.idx;
      end
    end else begin
      if (expQ.size() > 0 && cycleCount > expQ[0].cycle) begin
        monE = expQ.pop_front();
        checkOutput("valid_timeout", cycleCount, monE.cycle);
      end
      checkOutput("index_stable", index, lastIdx);
    end

    if (overrun) begin
      if (ovQ.size() == 0) begin
        checkOutput("unexpected_overrun", overrun, 0);
      end else begin
        monC = ovQ.pop_front();
        checkOutput("overrun_cycle", cycleCount, monC);
      end
    end else if (ovQ.size() > 0 && cycleCount > ovQ[0]) begin
      monC = ovQ.pop_front();
      checkOutput("overrun_timeout", cycleCount, monC);
    end

    expBusy = ((cycleCount >= bStart0) && (cycleCount <= bEnd0)) ||
              ((cycleCount >= bStart1) && (cycleCount <= bEnd1));
    checkOutput("busy", busy, expBusy);
  end

  initial begin
    reset_n   = 1'b0;
    acc_valid = 1'b0;
    dump      = 1'b0;
    acc_in    = '0;
    modelReset();
    doReset(3);

    // Hysteresis: target 21 from index 35, decays 35,35,35,34,34,34,34,33.
    for (int k = 0; k < 8; k++) fixedPeriod((k % 2 == 0) ? 36'h0_0010_0000 : 36'h F_FFF0_0000, 40);

    // Zero-peak period: 37-cycle latency, target 10.
    idleCycles(39);
    applyStimulus(1'b0, 36'd0, 1'b1);
    idleCycles(40);

    // Coincident 2^34 with dump after a 2^12 peak: immediate rise to 35.
    applyStimulus(1'b1, 36'h0_0000_1000, 1'b0);
    idleCycles(38);
    applyStimulus(1'b1, 36'h4_0000_0000, 1'b1);
    idleCycles(40);

    // Most negative sample: p=35, 2-cycle latency.
    applyStimulus(1'b1, 36'h8_0000_0000, 1'b1);
    idleCycles(40);

    // Overrun: second dump 10 cycles into a zero-peak scan; its large samples
    // must not leak into the third period.
    applyStimulus(1'b0, 36'd0, 1'b1);
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 36'h2_0000_0000, 1'b0);
    applyStimulus(1'b0, 36'd0, 1'b1);
    for (int i = 0; i < 30; i++) applyStimulus(1'b1, 36'h0_0000_0100, 1'b0);
    applyStimulus(1'b0, 36'd0, 1'b1);
    idleCycles(40);

    // Reset in the middle of a scan: no index_valid may follow.
    applyStimulus(1'b1, 36'h0_0000_0020, 1'b1);
    idleCycles(10);
    doReset(3);
    idleCycles(45);

    // Random periods, spacing short enough to provoke overruns sometimes.
    for (int k = 0; k < 60; k++) randomPeriod($urandom_range(15, 50));

    idleCycles(60);
    checkOutput("pending_index_valid", expQ.size(), 0);
    checkOutput("pending_overrun", ovQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
